sipo_rx_ctrl: RTL and testbench

Framed serial receiver controller that sequences a parameterized serial-in/parallel-out shift register. It detects a start bit on a one-bit-per-clock serial line, gates DATA_W shift cycles, checks optional even parity and the stop bit, and presents the assembled word on a valid/ready handshake. It sits between the raw serial pin and any parallel consumer of SIPO words.

---
 rtl/sipo_rx_pkg.sv | 21 ++
 rtl/sipo_shreg.sv | 37 +++
 rtl/sipo_rx_ctrl.sv | 158 +++++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types for the framed serial receiver: FSM state encoding and
// bit-counter sizing.
package sipo_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DATA     = 3'd1,
    PAR      = 3'd2,
    STOP     = 3'd3,
    ERR_WAIT = 3'd4
  } rx_state_e;

  // Counter width able to hold 0..data_w.
  function automatic int unsigned sipo_cnt_w(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

  localparam int unsigned DEFAULT_DATA_W = 3;
  localparam int unsigned DEFAULT_CNT_W  = $clog2(DEFAULT_DATA_W + 1);

endpackage

// File: rtl/sipo_shreg.sv
// Serial-in/parallel-out shift register. New bits enter at the MSB so the
// first bit of a frame ends up in bit 0.
module sipo_shreg #(
  parameter int DATA_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              shift_en_i,
  input  logic              serial_i,
  output logic [DATA_W-1:0] par_o
);

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;

  // Next-state: shift right on enable, otherwise hold.
  always_comb begin
    shreg_d = shreg_q;
    if (shift_en_i) begin
      shreg_d = {serial_i, shreg_q[DATA_W-1:1]};
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign par_o = shreg_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Framed serial receiver controller: start detection, DATA_W shift cycles,
// optional even parity, stop check and a one-word valid/ready holding register.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int DATA_W    = 3,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic [DATA_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned           CNT_W    = sipo_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] word_data_q, word_data_d;
  logic              word_valid_q, word_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;

  logic              shift_en_s;
  logic              complete_s;
  logic              perr_eff_s;
  logic [DATA_W-1:0] shreg_s;

  sipo_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk_i      (clk),
    .rst_ni     (reset),
    .shift_en_i (shift_en_s),
    .serial_i   (serial_in),
    .par_o      (shreg_s)
  );

  assign perr_eff_s = PARITY_EN ? perr_q : 1'b0;

  // Frame sequencing: next state, bit counter, parity capture, strobes.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    perr_d      = perr_q;
    shift_en_s  = 1'b0;
    complete_s  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!serial_in) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          state_d   = IDLE;
        end
      end
      DATA: begin
        shift_en_s = 1'b1;
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_CNT) begin
          state_d = PARITY_EN ? PAR : STOP;
        end else begin
          state_d = DATA;
        end
      end
      PAR: begin
        // Even parity: XOR of data and parity bit must be 0.
        perr_d  = (^shreg_s) ^ serial_in;
        state_d = STOP;
      end
      STOP: begin
        if (serial_in) begin
          complete_s = 1'b1;
          state_d    = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ERR_WAIT;
        end
      end
      ERR_WAIT: begin
        if (serial_in) begin
          state_d = IDLE;
        end else begin
          state_d = ERR_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Holding register: load on completion if free or freed this cycle.
  always_comb begin
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    if (complete_s) begin
      if (!word_valid_q || word_ready) begin
        word_data_d  = shreg_s;
        parity_err_d = perr_eff_s;
        word_valid_d = 1'b1;
      end else begin
        overrun_d    = 1'b1;
      end
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end else begin
      word_valid_d = word_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      perr_q       <= 1'b0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      perr_q       <= perr_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl: frame-level stimulus with a
// schedule-driven model of the holding register, for PARITY_EN=1 and 0.
module tb_sipo_rx_ctrl;

  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sp = 1'b1;
  logic          sn = 1'b1;
  logic          word_ready = 1'b0;
  logic [DW-1:0] wd1, wd0;
  logic          wv1, wv0, pe1, pe0, fe1, fe0, ov1, ov0, bz1, bz0;

  int            n_checks = 0;
  int            n_fail = 0;
  bit            pen = 1'b1;

  logic [DW-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          m_perr = 1'b0;

  sipo_rx_ctrl #(.DATA_W(DW), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .serial_in(sp), .word_data(wd1), .word_valid(wv1),
    .word_ready(word_ready), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(bz1)
  );

  sipo_rx_ctrl #(.DATA_W(DW), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .reset(reset), .serial_in(sn), .word_data(wd0), .word_valid(wv0),
    .word_ready(word_ready), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(bz0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (pen=%0d t=%0t): got %0h expected %0h", tag, pen, $time, obs, exp);
    end
  endtask

  task automatic check_all(input logic e_busy, input logic e_ferr, input logic e_ovr);
    chk("word_data",  8'(pen ? wd1 : wd0), 8'(m_data));
    chk("word_valid", 8'(pen ? wv1 : wv0), 8'(m_valid));
    chk("parity_err", 8'(pen ? pe1 : pe0), 8'(m_perr));
    chk("frame_err",  8'(pen ? fe1 : fe0), 8'(e_ferr));
    chk("overrun",    8'(pen ? ov1 : ov0), 8'(e_ovr));
    chk("busy",       8'(pen ? bz1 : bz0), 8'(e_busy));
  endtask

  // One line bit. ev: 0 none, 1 good frame ends at this edge, 2 bad stop.
  // rdy: 0/1 fixed, 2 random.
  task automatic tick(input logic b, input int ev, input logic [DW-1:0] w,
                      input logic pe, input logic bsy, input int rdy);
    logic r, e_ferr, e_ovr;
    @(negedge clk);
    if (pen) sp = b; else sn = b;
    r = (rdy == 2) ? (($urandom % 2) == 1) : (rdy == 1);
    word_ready = r;
    e_ferr = (ev == 2);
    e_ovr  = 1'b0;
    if (ev == 1) begin
      if (!m_valid || r) begin
        m_data = w; m_perr = pe; m_valid = 1'b1;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(bsy, e_ferr, e_ovr);
  endtask

  task automatic idle(input int n, input int rdy);
    for (int i = 0; i < n; i++) tick(1'b1, 0, '0, 1'b0, 1'b0, rdy);
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input logic bad_par, input logic stop_ok,
                            input int n_low, input int rdy, input int rdy_stop);
    logic pe;
    pe = pen ? bad_par : 1'b0;
    tick(1'b0, 0, w, pe, 1'b1, rdy);
    for (int i = 0; i < DW; i++) tick(w[i], 0, w, pe, 1'b1, rdy);
    if (pen) tick((^w) ^ bad_par, 0, w, pe, 1'b1, rdy);
    if (stop_ok) begin
      tick(1'b1, 1, w, pe, 1'b0, rdy_stop);
    end else begin
      tick(1'b0, 2, w, pe, 1'b1, rdy_stop);
      for (int i = 0; i < n_low; i++) tick(1'b0, 0, w, pe, 1'b1, rdy);
      tick(1'b1, 0, w, pe, 1'b0, rdy);
    end
  endtask

  task automatic clear_model();
    m_data = '0; m_valid = 1'b0; m_perr = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    #1;
    clear_model();
    check_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reset asserted asynchronously while the second data bit is on the line.
  task automatic reset_mid_frame(input logic [DW-1:0] w);
    tick(1'b0, 0, w, 1'b0, 1'b1, 0);
    tick(w[0], 0, w, 1'b0, 1'b1, 0);
    @(negedge clk);
    if (pen) sp = w[1]; else sn = w[1];
    #2;
    reset = 1'b0;
    #1;
    clear_model();
    check_all(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    sp = 1'b1;
    sn = 1'b1;
  endtask

  task automatic random_frames(input int n);
    logic [DW-1:0] w;
    for (int f = 0; f < n; f++) begin
      w = DW'($urandom);
      idle(int'($urandom % 3), 2);
      send_frame(w, ($urandom % 4) == 0, ($urandom % 6) != 0, int'($urandom % 4), 2, 2);
    end
  endtask

  initial begin
    #1;
    check_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    idle(10, 2);
    send_frame(3'b101, 1'b0, 1'b1, 0, 1, 1);
    idle(1, 1);
    send_frame(3'b011, 1'b1, 1'b1, 0, 0, 0);
    idle(2, 1);
    send_frame(3'b010, 1'b0, 1'b0, 3, 1, 1);
    send_frame(3'b100, 1'b0, 1'b1, 0, 1, 1);
    idle(1, 1);
    send_frame(3'b001, 1'b0, 1'b1, 0, 0, 0);
    send_frame(3'b110, 1'b0, 1'b1, 0, 0, 0);
    idle(1, 1);
    send_frame(3'b001, 1'b0, 1'b1, 0, 0, 0);
    send_frame(3'b110, 1'b0, 1'b1, 0, 0, 1);
    idle(1, 0);
    random_frames(40);
    send_frame(3'b111, 1'b0, 1'b1, 0, 0, 0);
    reset_mid_frame(3'b110);
    send_frame(3'b010, 1'b0, 1'b1, 0, 1, 1);
    idle(2, 2);

    pen = 1'b0;
    reset_pulse();
    idle(2, 2);
    send_frame(3'b010, 1'b0, 1'b1, 0, 1, 1);
    idle(1, 1);
    send_frame(3'b101, 1'b0, 1'b1, 0, 0, 0);
    reset_mid_frame(3'b011);
    send_frame(3'b010, 1'b0, 1'b1, 0, 0, 1);
    random_frames(30);
    idle(2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
